// File: rtl/csr_target_timer_regs.sv
// csr_target_timer_regs
// CSR-bus target: a prescaled 32-bit up-counter with compare/interrupt plus
// four scratch registers. Responses are all-zero when this target is not
// addressed, so several targets can be OR-combined onto one master.
module csr_target_timer_regs #(
   parameter logic [15:0] CSR_SELECT = 16'h0001,
   parameter int unsigned PRESCALE   = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        csr_request__valid,
   input  logic        csr_request__read_not_write,
   input  logic [15:0] csr_request__select,
   input  logic [15:0] csr_request__address,
   input  logic [31:0] csr_request__data,
   output logic        csr_response__acknowledge,
   output logic        csr_response__read_data_valid,
   output logic        csr_response__read_data_error,
   output logic [31:0] csr_response__read_data,
   output logic        timer_irq
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACK  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam logic [3:0] A_CTRL    = 4'd0;
   localparam logic [3:0] A_STATUS  = 4'd1;
   localparam logic [3:0] A_COUNTER = 4'd2;
   localparam logic [3:0] A_COMPARE = 4'd3;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_RELOAD = 2;

   localparam logic [31:0] PRESCALE_MAX = 32'(PRESCALE);

   // Bus-side state
   logic [1:0]  r_state;
   logic        r_rnw;
   logic [31:0] r_rdata;
   logic        r_rerr;

   // Register bank
   logic [2:0]  r_ctrl;
   logic        r_pending;
   logic [31:0] r_counter;
   logic [31:0] r_compare;
   logic [31:0] r_scratch [4];
   logic [31:0] r_pre;
   logic        r_irq;

   // Decode / timer wires
   logic        w_hit;
   logic        w_accept;
   logic        w_wr;
   logic [3:0]  w_addr;
   logic        w_wr_ctrl;
   logic        w_wr_status;
   logic        w_wr_counter;
   logic        w_wr_compare;
   logic        w_wr_scratch;
   logic        w_pre_wrap;
   logic        w_cmp_evt;
   logic [31:0] w_rd_data;
   logic        w_rd_err;
   logic        w_unused;

   // Upper address bits are don't-care for this target.
   assign w_unused = ^csr_request__address[15:4];

   assign w_hit    = csr_request__valid && (csr_request__select == CSR_SELECT);
   assign w_addr   = csr_request__address[3:0];
   // Only IDLE accepts, so a request held through ACK is applied exactly once.
   assign w_accept = (r_state == ST_IDLE) && w_hit;
   assign w_wr     = w_accept && !csr_request__read_not_write;

   assign w_wr_ctrl    = w_wr && (w_addr == A_CTRL);
   assign w_wr_status  = w_wr && (w_addr == A_STATUS);
   assign w_wr_counter = w_wr && (w_addr == A_COUNTER);
   assign w_wr_compare = w_wr && (w_addr == A_COMPARE);
   assign w_wr_scratch = w_wr && (w_addr[3:2] == 2'b01);

   assign w_pre_wrap = r_ctrl[CTRL_EN] && (r_pre == PRESCALE_MAX);
   assign w_cmp_evt  = w_pre_wrap && (r_counter == r_compare);

   // Read-value mux for the addressed register, sampled when a request is accepted
   always_comb begin
      // NOTE: defaults first so every path assigns every output -- no latch.
      w_rd_data = '0;
      w_rd_err  = 1'b0;
      case (w_addr)
         A_CTRL:    w_rd_data = {29'd0, r_ctrl};
         A_STATUS:  w_rd_data = {31'd0, r_pending};
         A_COUNTER: w_rd_data = r_counter;
         A_COMPARE: w_rd_data = r_compare;
         4'd4, 4'd5, 4'd6, 4'd7: w_rd_data = r_scratch[w_addr[1:0]];
         default:   w_rd_err  = 1'b1;
      endcase
   end

   // Request FSM: IDLE -> ACK (held while valid) -> DATA for reads -> IDLE
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_rnw   <= 1'b0;
         r_rdata <= '0;
         r_rerr  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hit) begin
                  r_state <= ST_ACK;
                  r_rnw   <= csr_request__read_not_write;
                  r_rdata <= w_rd_data;
                  r_rerr  <= w_rd_err;
               end
            end
            ST_ACK: begin
               if (!w_hit) r_state <= r_rnw ? ST_DATA : ST_IDLE;
            end
            ST_DATA: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Control register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       r_ctrl <= '0;
      else if (w_wr_ctrl) r_ctrl <= csr_request__data[2:0];
   end

   // Compare register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          r_compare <= 32'hFFFF_FFFF;
      else if (w_wr_compare) r_compare <= csr_request__data;
   end

   // Scratch registers
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: only four words, so they are flops with a reset, not a RAM.
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) r_scratch[i] <= '0;
      end else if (w_wr_scratch) begin
         r_scratch[w_addr[1:0]] <= csr_request__data;
      end
   end

   // Prescaler: counts 0..PRESCALE while enabled, holds otherwise
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                r_pre <= '0;
      else if (r_ctrl[CTRL_EN])    r_pre <= w_pre_wrap ? '0 : r_pre + 32'd1;
   end

   // Counter: bus write wins over reload, reload wins over increment
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          r_counter <= '0;
      else if (w_wr_counter) r_counter <= csr_request__data;
      else if (w_pre_wrap)   r_counter <= (w_cmp_evt && r_ctrl[CTRL_RELOAD]) ? '0
                                                                             : r_counter + 32'd1;
   end

   // Pending flag: a compare event wins over a same-cycle write-1-to-clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                r_pending <= 1'b0;
      else if (w_cmp_evt)                          r_pending <= 1'b1;
      else if (w_wr_status && csr_request__data[0]) r_pending <= 1'b0;
   end

   // Interrupt output, one cycle behind the pending flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_irq <= 1'b0;
      else          r_irq <= r_pending & r_ctrl[CTRL_IRQ_EN];
   end

   assign csr_response__acknowledge     = (r_state == ST_ACK);
   assign csr_response__read_data_valid = (r_state == ST_DATA);
   assign csr_response__read_data_error = (r_state == ST_DATA) && r_rerr;
   assign csr_response__read_data       = (r_state == ST_DATA) ? r_rdata : '0;
   assign timer_irq                     = r_irq;

endmodule

// File: tb/tb_csr_target_timer_regs.sv
// tb_csr_target_timer_regs
// Directed bench for csr_target_timer_regs. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_csr_target_timer_regs;

   localparam logic [15:0] SEL = 16'h0001;

   logic        clk;
   logic        reset_n;
   logic        valid;
   logic        rnw;
   logic [15:0] sel;
   logic [15:0] addr;
   logic [31:0] wdata;
   logic        ack;
   logic        rdv;
   logic        rerr;
   logic [31:0] rdata;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   csr_target_timer_regs #(
      .CSR_SELECT (SEL),
      .PRESCALE   (0)
   ) dut (
      .clk                           (clk),
      .reset_n                       (reset_n),
      .csr_request__valid            (valid),
      .csr_request__read_not_write   (rnw),
      .csr_request__select           (sel),
      .csr_request__address          (addr),
      .csr_request__data             (wdata),
      .csr_response__acknowledge     (ack),
      .csr_response__read_data_valid (rdv),
      .csr_response__read_data_error (rerr),
      .csr_response__read_data       (rdata),
      .timer_irq                     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge after the DUT is back in IDLE.
   task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
      valid = 1'b1; rnw = 1'b0; sel = SEL; addr = a; wdata = d;
      @(negedge clk);
      check("wr_ack", ack, 1);
      valid = 1'b0;
      @(negedge clk);
      check("wr_ack_drop", ack, 0);
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic e);
      valid = 1'b1; rnw = 1'b1; sel = SEL; addr = a; wdata = '0;
      @(negedge clk);
      check("rd_ack", ack, 1);
      check("rd_no_early_data", rdv, 0);
      valid = 1'b0;
      @(negedge clk);
      check("rd_valid", rdv, 1);
      d = rdata;
      e = rerr;
      @(negedge clk);
      check("rd_valid_drop", rdv, 0);
   endtask

   task automatic rd_check(input string tag, input logic [15:0] a,
                           input logic [31:0] exp_d, input logic exp_e);
      logic [31:0] d;
      logic        e;
      bus_read(a, d, e);
      check(tag, d, exp_d);
      check({tag, "_err"}, e, exp_e);
   endtask

   initial begin
      reset_n = 1'b0; valid = 1'b0; rnw = 1'b0; sel = '0; addr = '0; wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_ack", ack, 0);
      check("rst_rdv", rdv, 0);
      check("rst_rdata", rdata, 0);
      check("rst_rerr", rerr, 0);
      check("rst_irq", irq, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Reset values through the bus
      rd_check("rst_compare", 16'd3, 32'hFFFF_FFFF, 1'b0);
      rd_check("rst_ctrl",    16'd0, 32'h0, 1'b0);
      rd_check("rst_counter", 16'd2, 32'h0, 1'b0);
      rd_check("rst_status",  16'd1, 32'h0, 1'b0);
      rd_check("rst_scratch0",16'd4, 32'h0, 1'b0);

      // Scratch and plain register access
      bus_write(16'd6, 32'hDEAD_BEEF);
      rd_check("scratch2", 16'd6, 32'hDEAD_BEEF, 1'b0);
      bus_write(16'd2, 32'd4);
      rd_check("counter_hold", 16'd2, 32'd4, 1'b0);
      bus_write(16'd0, 32'hFFFF_FFF8);
      rd_check("ctrl_unused_bits", 16'd0, 32'h0, 1'b0);

      // Foreign select: ignored while held for several cycles
      valid = 1'b1; rnw = 1'b0; sel = 16'h0002; addr = 16'd6; wdata = 32'h1111_1111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("foreign_ack", ack, 0);
         check("foreign_rdv", rdv, 0);
         check("foreign_rdata", rdata, 0);
      end
      rnw = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("foreign_rd_ack", ack, 0);
         check("foreign_rd_rdata", rdata, 0);
      end
      valid = 1'b0;
      @(negedge clk);
      rd_check("scratch2_untouched", 16'd6, 32'hDEAD_BEEF, 1'b0);

      // Request held in ACK with changing data is applied once
      valid = 1'b1; rnw = 1'b0; sel = SEL; addr = 16'd7; wdata = 32'h0000_0001;
      @(negedge clk);
      check("hold_ack0", ack, 1);
      wdata = 32'h0000_0002;
      repeat (2) begin
         @(negedge clk);
         check("hold_ack", ack, 1);
      end
      valid = 1'b0;
      @(negedge clk);
      check("hold_ack_drop", ack, 0);
      rd_check("write_once", 16'd7, 32'h1, 1'b0);

      // Unmapped addresses and ignored upper address bits
      bus_write(16'd4, 32'hA5A5_A5A5);
      rd_check("unmapped9", 16'd9, 32'h0, 1'b1);
      rd_check("unmapped15", 16'd15, 32'h0, 1'b1);
      bus_write(16'd9, 32'hFFFF_FFFF);
      bus_write(16'd12, 32'h1234_5678);
      rd_check("scratch0_kept", 16'd4, 32'hA5A5_A5A5, 1'b0);
      rd_check("compare_kept", 16'd3, 32'hFFFF_FFFF, 1'b0);
      bus_write(16'h0015, 32'h5555_0000);
      rd_check("upper_addr_ignored", 16'd5, 32'h5555_0000, 1'b0);

      // Counter write beats increment; no reload, event still sets pending
      bus_write(16'd0, 32'd0);
      bus_write(16'd1, 32'd1);
      bus_write(16'd3, 32'd5);
      bus_write(16'd2, 32'd0);
      bus_write(16'd0, 32'd3);          // enable + irq_enable, counter 0 -> 1
      bus_write(16'd2, 32'd4);          // counter forced to 4, then 5
      rd_check("cnt_after_write", 16'd2, 32'd5, 1'b0);
      rd_check("cnt_continues",   16'd2, 32'd8, 1'b0);
      rd_check("noreload_pending",16'd1, 32'd1, 1'b0);
      check("noreload_irq", irq, 1);

      // Auto-reload with compare 5: period of 6 clocks
      bus_write(16'd0, 32'd0);
      bus_write(16'd1, 32'd1);
      bus_write(16'd2, 32'd0);
      bus_write(16'd3, 32'd5);
      check("irq_off", irq, 0);
      bus_write(16'd0, 32'd7);          // event five falling edges from here
      repeat (5) @(negedge clk);
      check("irq_lags_pending", irq, 0);
      @(negedge clk);
      check("irq_rise1", irq, 1);
      bus_write(16'd1, 32'd1);
      check("irq_cleared", irq, 0);
      repeat (3) @(negedge clk);
      check("irq_before_period", irq, 0);
      @(negedge clk);
      check("irq_rise2", irq, 1);
      rd_check("cnt_reloaded", 16'd2, 32'd1, 1'b0);
      @(negedge clk);
      bus_write(16'd1, 32'd1);          // clear lands on an event edge
      rd_check("event_beats_clear", 16'd1, 32'd1, 1'b0);
      bus_write(16'd0, 32'd0);
      bus_write(16'd1, 32'd1);
      rd_check("status_cleared", 16'd1, 32'd0, 1'b0);
      @(negedge clk);
      check("irq_final_off", irq, 0);

      // Reset during a read's ACK phase
      bus_write(16'd3, 32'd9);
      valid = 1'b1; rnw = 1'b1; sel = SEL; addr = 16'd6; wdata = '0;
      @(negedge clk);
      check("mid_rd_ack", ack, 1);
      reset_n = 1'b0;
      valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("mid_rst_rdv", rdv, 0);
         check("mid_rst_rdata", rdata, 0);
         check("mid_rst_ack", ack, 0);
      end
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_rdv", rdv, 0);
      rd_check("post_rst_compare", 16'd3, 32'hFFFF_FFFF, 1'b0);
      rd_check("post_rst_scratch2",16'd6, 32'h0, 1'b0);
      rd_check("post_rst_scratch3",16'd7, 32'h0, 1'b0);
      rd_check("post_rst_counter", 16'd2, 32'h0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
